// File: rtl/packet_pattern_classer_if.sv
// packet_pattern_classer_if: Avalon-ST stream bundle (data, framing, empty,
// valid/ready handshake) shared by the sink and source sides of the classer.
// The master modport drives the beat and receives ready; the slave modport
// receives the beat and drives ready.
interface packet_pattern_classer_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int EMPTY_WIDTH = 2
);
  logic [DATA_WIDTH-1:0]  data;
  logic                   valid;
  logic                   startofpacket;
  logic                   endofpacket;
  logic [EMPTY_WIDTH-1:0] empty;
  logic                   ready;

  modport master (
    output data, valid, startofpacket, endofpacket, empty,
    input  ready
  );

  modport slave (
    input  data, valid, startofpacket, endofpacket, empty,
    output ready
  );
endinterface

// File: rtl/packet_pattern_classer.sv
// packet_pattern_classer: one-stage Avalon-ST pipeline that scans each packet
// for a 12-symbol key and reports the result on the packet's EOP beat.
// The key and the enable bit are captured on the SOP beat so control register
// writes during a packet only take effect from the next packet onwards.
// Optional build macro PATTERN_CLASSER_STATS_EN adds free-running packet and
// match counters (pkt_cnt_o / match_cnt_o) that advance on source EOP beats.
module packet_pattern_classer #(
  parameter int DATA_WIDTH  = 32,
  parameter int EMPTY_WIDTH = 2,
  parameter int PAT_WORDS   = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [PAT_WORDS-1:0][31:0]  pattern_i,
  input  logic                        enable_i,
  packet_pattern_classer_if.slave     snk,
  packet_pattern_classer_if.master    src,
  output logic                        match_o
`ifdef PATTERN_CLASSER_STATS_EN
  ,
  output logic [31:0]                 pkt_cnt_o,
  output logic [31:0]                 match_cnt_o
`endif
);

  localparam int BEAT_SYMS = DATA_WIDTH / 8;
  localparam int KEY_SYMS  = PAT_WORDS * 4;
  localparam int SEQ_SYMS  = KEY_SYMS + BEAT_SYMS;
  localparam int CNT_W     = $clog2(KEY_SYMS + 1);

  typedef logic [7:0] sym_t;
  typedef enum logic {IDLE, IN_PKT} state_t;

  // Packet tracking and scan history
  state_t                      state_q;
  sym_t [KEY_SYMS-1:0]         hist_q;
  sym_t [KEY_SYMS-1:0]         hist_d;
  logic [CNT_W-1:0]            cnt_q;
  logic [CNT_W-1:0]            cnt_d;
  logic                        found_q;
  logic                        found_d;
  logic                        enable_q;
  logic [PAT_WORDS-1:0][31:0]  pattern_q;

  // Output register
  logic                        srcValid_q;
  logic [DATA_WIDTH-1:0]       srcData_q;
  logic                        srcSop_q;
  logic                        srcEop_q;
  logic [EMPTY_WIDTH-1:0]      srcEmpty_q;
  logic                        match_q;
  logic                        match_d;

  // Combinational scan helpers
  logic                        snkAccept;
  logic                        srcAccept;
  logic                        scanBeat;
  logic [PAT_WORDS-1:0][31:0]  patternEff;
  logic                        enableEff;
  sym_t [KEY_SYMS-1:0]         keySym;
  sym_t [KEY_SYMS-1:0]         histBase;
  logic [CNT_W-1:0]            cntBase;
  logic                        foundBase;
  sym_t [SEQ_SYMS-1:0]         seq;
  logic                        windowEq;
  logic                        beatHit;
  int                          validSyms;
  int                          cntSum;

  assign snk.ready = src.ready | ~srcValid_q;
  assign snkAccept = snk.valid & snk.ready;
  assign srcAccept = srcValid_q & src.ready;
  assign scanBeat  = snk.startofpacket | (state_q == IN_PKT);

  assign src.valid         = srcValid_q;
  assign src.data          = srcData_q;
  assign src.startofpacket = srcSop_q;
  assign src.endofpacket   = srcEop_q;
  assign src.empty         = srcEmpty_q;
  assign match_o           = match_q;

  // Scan the incoming beat: build history-plus-beat sequence, test each key window, and form the next history.
  always_comb begin
    patternEff = snk.startofpacket ? pattern_i : pattern_q;
    enableEff  = snk.startofpacket ? enable_i : enable_q;
    histBase   = snk.startofpacket ? '0 : hist_q;
    cntBase    = snk.startofpacket ? '0 : cnt_q;
    foundBase  = snk.startofpacket ? 1'b0 : found_q;

    for (int i = 0; i < KEY_SYMS; i++) begin
      keySym[i] = patternEff[i/4][31-8*(i%4) -: 8];
    end

    for (int i = 0; i < KEY_SYMS; i++) begin
      seq[i] = histBase[i];
    end
    for (int k = 0; k < BEAT_SYMS; k++) begin
      seq[KEY_SYMS+k] = snk.data[DATA_WIDTH-1-8*k -: 8];
    end

    validSyms = snk.endofpacket ? (BEAT_SYMS - int'(snk.empty)) : BEAT_SYMS;

    windowEq = 1'b0;
    beatHit  = 1'b0;
    for (int j = 0; j < BEAT_SYMS; j++) begin
      windowEq = 1'b1;
      for (int i = 0; i < KEY_SYMS; i++) begin
        if (seq[j+1+i] != keySym[i]) begin
          windowEq = 1'b0;
        end
      end
      if (windowEq && (j < validSyms) && (int'(cntBase) + j + 1 >= KEY_SYMS)) begin
        beatHit = 1'b1;
      end
    end

    hist_d = histBase;
    for (int n = 1; n <= BEAT_SYMS; n++) begin
      if (validSyms == n) begin
        for (int i = 0; i < KEY_SYMS; i++) begin
          hist_d[i] = seq[n+i];
        end
      end
    end

    cntSum  = int'(cntBase) + validSyms;
    cnt_d   = (cntSum >= KEY_SYMS) ? CNT_W'(KEY_SYMS) : CNT_W'(cntSum);
    found_d = foundBase | beatHit;
    match_d = scanBeat & snk.endofpacket & enableEff & found_d;
  end

  // Packet FSM: track SOP/EOP framing, capture key/enable at SOP and advance the scan history.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      hist_q    <= '0;
      cnt_q     <= '0;
      found_q   <= 1'b0;
      enable_q  <= 1'b0;
      pattern_q <= '0;
    end else if (snkAccept && scanBeat) begin
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
      if (snk.startofpacket) begin
        pattern_q <= pattern_i;
        enable_q  <= enable_i;
      end
      state_q <= snk.endofpacket ? IDLE : IN_PKT;
    end
  end

  // Output register: load on sink acceptance, drop valid once the source side drains it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      srcValid_q <= 1'b0;
      srcData_q  <= '0;
      srcSop_q   <= 1'b0;
      srcEop_q   <= 1'b0;
      srcEmpty_q <= '0;
      match_q    <= 1'b0;
    end else if (snkAccept) begin
      srcValid_q <= 1'b1;
      srcData_q  <= snk.data;
      srcSop_q   <= snk.startofpacket;
      srcEop_q   <= snk.endofpacket;
      srcEmpty_q <= snk.empty;
      match_q    <= match_d;
    end else if (srcAccept) begin
      srcValid_q <= 1'b0;
    end
  end

`ifdef PATTERN_CLASSER_STATS_EN
  logic [31:0] pktCnt_q;
  logic [31:0] matchCnt_q;

  // Statistics: count packets and matching packets as their EOP beat leaves the block.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pktCnt_q   <= '0;
      matchCnt_q <= '0;
    end else if (srcAccept && srcEop_q) begin
      pktCnt_q <= pktCnt_q + 32'd1;
      if (match_q) begin
        matchCnt_q <= matchCnt_q + 32'd1;
      end
    end
  end

  assign pkt_cnt_o   = pktCnt_q;
  assign match_cnt_o = matchCnt_q;
`endif

endmodule

// File: tb/tb_packet_pattern_classer.sv
// tb_packet_pattern_classer: drives directed and randomized packets into the
// classer and compares every source beat against a packet-level reference:
// a packet matches when the key occurs as a contiguous run of its valid
// symbols and the enable bit was set at SOP.
module tb_packet_pattern_classer;

  localparam int DATA_WIDTH  = 32;
  localparam int EMPTY_WIDTH = 2;
  localparam int PAT_WORDS   = 3;
  localparam logic [PAT_WORDS-1:0][31:0] KEY_PATTERN = {32'h494A4B4C, 32'h45464748, 32'h41424344};

  typedef logic [7:0] sym_t;
  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic        match;
  } beat_t;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [PAT_WORDS-1:0][31:0] pattern;
  logic                       enable;
  logic                       matchOut;
`ifdef PATTERN_CLASSER_STATS_EN
  logic [31:0]                pktCnt;
  logic [31:0]                matchCnt;
`endif

  packet_pattern_classer_if #(.DATA_WIDTH(DATA_WIDTH), .EMPTY_WIDTH(EMPTY_WIDTH)) snkIf ();
  packet_pattern_classer_if #(.DATA_WIDTH(DATA_WIDTH), .EMPTY_WIDTH(EMPTY_WIDTH)) srcIf ();

  packet_pattern_classer #(
    .DATA_WIDTH (DATA_WIDTH),
    .EMPTY_WIDTH(EMPTY_WIDTH),
    .PAT_WORDS  (PAT_WORDS)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .pattern_i  (pattern),
    .enable_i   (enable),
    .snk        (snkIf),
    .src        (srcIf),
    .match_o    (matchOut)
`ifdef PATTERN_CLASSER_STATS_EN
    ,
    .pkt_cnt_o  (pktCnt),
    .match_cnt_o(matchCnt)
`endif
  );

  always #5 clk = ~clk;

  int    checkCount = 0;
  int    passCount  = 0;
  beat_t expQ[$];
  sym_t  pkt[$];
  sym_t  key[12];
  logic  randomReady = 1'b0;
  beat_t lastBeat;

  // Count one comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      passCount++;
    end
  endtask

  // Reference: does the key appear as a contiguous run of the packet's symbols?
  function automatic bit containsKey();
    for (int s = 0; s + 12 <= pkt.size(); s++) begin
      bit ok = 1'b1;
      for (int i = 0; i < 12; i++) begin
        if (pkt[s+i] != key[i]) ok = 1'b0;
      end
      if (ok) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic pushKey(input int first, input int count);
    for (int i = first; i < first + count; i++) pkt.push_back(key[i]);
  endtask

  // Random symbols, often drawn from the key alphabet to create near-misses.
  task automatic pushRandom(input int count);
    for (int i = 0; i < count; i++) begin
      if ($urandom_range(0, 1) == 1) pkt.push_back(sym_t'($urandom_range(8'h41, 8'h4C)));
      else pkt.push_back(sym_t'($urandom));
    end
  endtask

  // Present one sink beat and hold it until accepted (bounded), then log its expected output.
  task automatic applyStimulus(input beat_t bt);
    int waitCycles = 0;
    bit acc = 1'b0;
    snkIf.valid         = 1'b1;
    snkIf.data          = bt.data;
    snkIf.startofpacket = bt.sop;
    snkIf.endofpacket   = bt.eop;
    snkIf.empty         = bt.empty;
    do begin
      @(negedge clk);
      acc = snkIf.ready;
      @(posedge clk);
      #1;
      waitCycles++;
    end while (!acc && waitCycles < 200);
    if (!acc) checkOutput("sink_accept_timeout", 64'd0, 64'd1);
    else begin
      expQ.push_back(bt);
      lastBeat = bt;
    end
    snkIf.valid = 1'b0;
  endtask

  // Send the symbols in pkt as a packet; optionally stop after beatLimit beats.
  task automatic sendPacket(input bit enSop, input bit enMid, input sym_t padByte,
                            input int beatLimit, input bit gaps, input bit scramble);
    int nBeats = (pkt.size() + 3) / 4;
    bit pktMatch;
    enable   = enSop;
    pattern  = KEY_PATTERN;
    pktMatch = enSop && containsKey();
    for (int b = 0; b < nBeats && b < beatLimit; b++) begin
      beat_t bt;
      int padIdx = 0;
      for (int k = 0; k < 4; k++) begin
        sym_t s;
        if (4*b + k < pkt.size()) s = pkt[4*b+k];
        else begin
          s = (padIdx == 0) ? padByte : sym_t'($urandom);
          padIdx++;
        end
        bt.data[31-8*k -: 8] = s;
      end
      bt.sop   = (b == 0);
      bt.eop   = (b == nBeats - 1);
      bt.empty = bt.eop ? 2'(4*nBeats - pkt.size()) : 2'($urandom);
      bt.match = bt.eop && pktMatch;
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(bt);
      if (b == 0) begin
        enable = enMid;
        if (scramble) pattern = {$urandom, $urandom, $urandom};
      end
    end
    pattern = KEY_PATTERN;
  endtask

  // Wait (bounded) until every logged beat has left the source side.
  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain", 64'(expQ.size()), 64'd0);
  endtask

  // Random source backpressure, changed just after each active edge.
  always @(posedge clk) begin
    #1;
    srcIf.ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic [37:0] curOut;
  logic [37:0] heldOut;
  logic        prevStall = 1'b0;
  beat_t       monExp;

  // Source monitor: scoreboard each accepted beat and verify outputs hold while stalled.
  always @(negedge clk) begin
    curOut = {srcIf.data, srcIf.startofpacket, srcIf.endofpacket, srcIf.empty, matchOut, srcIf.valid};
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) checkOutput("stall_hold", 64'(curOut), 64'(heldOut));
      if (srcIf.valid && srcIf.ready) begin
        if (expQ.size() == 0) checkOutput("extra_beat", 64'd1, 64'd0);
        else begin
          monExp = expQ.pop_front();
          checkOutput("out_data", 64'(srcIf.data), 64'(monExp.data));
          checkOutput("out_sop", 64'(srcIf.startofpacket), 64'(monExp.sop));
          checkOutput("out_eop", 64'(srcIf.endofpacket), 64'(monExp.eop));
          checkOutput("out_empty", 64'(srcIf.empty), 64'(monExp.empty));
          checkOutput("out_match", 64'(matchOut), 64'(monExp.match));
        end
      end
      prevStall = srcIf.valid && !srcIf.ready;
      heldOut   = curOut;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d so far", passCount, checkCount);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    beat_t stray;
    for (int i = 0; i < 12; i++) key[i] = sym_t'(8'h41 + i);
    pattern             = KEY_PATTERN;
    enable              = 1'b1;
    snkIf.valid         = 1'b0;
    snkIf.data          = '0;
    snkIf.startofpacket = 1'b0;
    snkIf.endofpacket   = 1'b0;
    snkIf.empty         = '0;
    srcIf.ready         = 1'b1;

    // Reset state
    #3;
    checkOutput("rst_src_valid", 64'(srcIf.valid), 64'd0);
    checkOutput("rst_match", 64'(matchOut), 64'd0);
    checkOutput("rst_src_data", 64'(srcIf.data), 64'd0);
    checkOutput("rst_src_framing", 64'({srcIf.startofpacket, srcIf.endofpacket, srcIf.empty}), 64'd0);
    checkOutput("rst_snk_ready", 64'(snkIf.ready), 64'd1);
`ifdef PATTERN_CLASSER_STATS_EN
    checkOutput("rst_counters", {pktCnt, matchCnt}, 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Word-aligned key in beats 1-3, plus one-cycle latency check
    $display("[TB] aligned key");
    pkt.delete();
    pushRandom(4);
    pushKey(0, 12);
    sendPacket(1'b1, 1'b1, 8'h00, 99, 1'b0, 1'b0);
    checkOutput("latency_valid", 64'(srcIf.valid), 64'd1);
    checkOutput("latency_data", 64'(srcIf.data), 64'(lastBeat.data));
    checkOutput("aligned_match", 64'(matchOut), 64'd1);

    // Key shifted by two symbols, last beat empty = 2
    $display("[TB] shifted key");
    pkt.delete();
    pkt.push_back(8'h30);
    pkt.push_back(8'h30);
    pushKey(0, 12);
    sendPacket(1'b1, 1'b1, 8'h00, 99, 1'b0, 1'b0);
    checkOutput("shifted_match", 64'(matchOut), 64'd1);

    // Same packet with the final 'L' in an unused (empty) lane
    pkt.delete();
    pkt.push_back(8'h30);
    pkt.push_back(8'h30);
    pushKey(0, 11);
    sendPacket(1'b1, 1'b1, 8'h4C, 99, 1'b0, 1'b0);
    checkOutput("empty3_match", 64'(matchOut), 64'd0);

    // Key split across two packets
    $display("[TB] split key");
    pkt.delete();
    pushRandom(6);
    pushKey(0, 6);
    sendPacket(1'b1, 1'b1, 8'h00, 99, 1'b0, 1'b0);
    pkt.delete();
    pushKey(6, 6);
    pushRandom(6);
    sendPacket(1'b1, 1'b1, 8'h00, 99, 1'b0, 1'b0);

    // Enable low at SOP then raised mid-packet, followed by the same packet enabled
    $display("[TB] enable latching");
    pkt.delete();
    pushRandom(4);
    pushKey(0, 12);
    sendPacket(1'b0, 1'b1, 8'h00, 99, 1'b0, 1'b0);
    checkOutput("late_enable_match", 64'(matchOut), 64'd0);
    sendPacket(1'b1, 1'b1, 8'h00, 99, 1'b0, 1'b0);
    checkOutput("enabled_match", 64'(matchOut), 64'd1);

    // Beat outside any packet passes through unscanned
    stray.data  = 32'h41424344;
    stray.sop   = 1'b0;
    stray.eop   = 1'b1;
    stray.empty = 2'd1;
    stray.match = 1'b0;
    applyStimulus(stray);
    waitDrain();

    // Randomized packets under random backpressure, with key scrambled after SOP
    $display("[TB] random packets");
    randomReady = 1'b1;
    for (int p = 0; p < 20; p++) begin
      bit en;
      pkt.delete();
      if ($urandom_range(0, 1) == 1) begin
        pushRandom($urandom_range(0, 8));
        pushKey(0, 12);
        pushRandom($urandom_range(0, 4));
      end else begin
        pushRandom($urandom_range(1, 24));
      end
      en = ($urandom_range(0, 3) != 0);
      sendPacket(en, en, sym_t'($urandom), 99, 1'b1, 1'b1);
    end
    randomReady = 1'b0;
    waitDrain();

    // Reset in the middle of a packet, then a clean matching packet
    $display("[TB] mid-packet reset");
    pkt.delete();
    pushRandom(4);
    pushKey(0, 12);
    sendPacket(1'b1, 1'b1, 8'h00, 2, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_src_valid", 64'(srcIf.valid), 64'd0);
    checkOutput("midrst_match", 64'(matchOut), 64'd0);
    checkOutput("midrst_snk_ready", 64'(snkIf.ready), 64'd1);
    expQ.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    sendPacket(1'b1, 1'b1, 8'h00, 99, 1'b0, 1'b0);
    checkOutput("post_rst_match", 64'(matchOut), 64'd1);
    waitDrain();
    @(posedge clk);
    #1;
`ifdef PATTERN_CLASSER_STATS_EN
    checkOutput("stats_pkt_cnt", 64'(pktCnt), 64'd1);
    checkOutput("stats_match_cnt", 64'(matchCnt), 64'd1);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
